// File: rtl/branch_history_table.sv
// Branch direction predictor: table of 2-bit saturating counters with a single write port.
// Optional performance counters are built when BHT_PERF_CNT_EN is defined.
module branch_history_table #(
   parameter int unsigned NUM_ENTRIES = 64,
   parameter logic [1:0]  RESET_STATE = 2'b01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   output logic [1:0]  pred_state,
   output logic        pred_taken,
   output logic        ready,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [1:0]  upd_pred,
   output logic        mispredict,
   output logic [31:0] perf_branches,
   output logic [31:0] perf_mispredicts
);

   localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e            state_q;
   logic [IDX_W-1:0]  init_idx_q;

   logic [1:0]        table_q [NUM_ENTRIES];

   logic              pw_valid_q;
   logic [IDX_W-1:0]  pw_idx_q;
   logic [1:0]        pw_state_q;
   logic              pw_valid_d;
   logic [IDX_W-1:0]  pw_idx_d;
   logic [1:0]        pw_state_d;

   logic [IDX_W-1:0]  lk_idx;
   logic [IDX_W-1:0]  up_idx;
   logic [1:0]        lk_val;
   logic [1:0]        up_cur;
   logic              accept;

   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [1:0]        wr_data;

   logic              unused_bits;

   function automatic logic [1:0] ctr_next(input logic [1:0] cur, input logic taken);
      logic [1:0] nxt;
      if (taken) begin
         nxt = (cur == 2'b11) ? 2'b11 : cur + 2'b01;
      end else begin
         nxt = (cur == 2'b00) ? 2'b00 : cur - 2'b01;
      end
      return nxt;
   endfunction

   assign lk_idx      = if_pc[IDX_W+1:2];
   assign up_idx      = upd_pc[IDX_W+1:2];
   assign ready       = (state_q == ST_RUN);
   assign accept      = upd_valid & ready;
   assign mispredict  = accept & (upd_pred[1] != upd_taken);
   assign pred_taken  = pred_state[1];
   assign unused_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0], upd_pc[31:IDX_W+2], upd_pc[1:0], upd_pred[0]};

   // Init sweep: one entry per cycle, then hold in RUN until the next reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_INIT;
         init_idx_q <= '0;
      end else begin
         case (state_q)
            ST_INIT: begin
               if (init_idx_q == LAST_IDX) begin
                  state_q <= ST_RUN;
               end else begin
                  init_idx_q <= init_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
               end
            end
            ST_RUN: begin
               state_q <= ST_RUN;
            end
            default: begin
               state_q    <= ST_INIT;
               init_idx_q <= '0;
            end
         endcase
      end
   end

   // Read paths; the pending write overrides the array so back-to-back updates accumulate.
   always_comb begin
      lk_val = table_q[lk_idx];
      if (pw_valid_q && (pw_idx_q == lk_idx)) begin
         lk_val = pw_state_q;
      end else begin
         lk_val = table_q[lk_idx];
      end
      if (state_q == ST_RUN) begin
         pred_state = lk_val;
      end else begin
         pred_state = RESET_STATE;
      end
      if (pw_valid_q && (pw_idx_q == up_idx)) begin
         up_cur = pw_state_q;
      end else begin
         up_cur = table_q[up_idx];
      end
   end

   always_comb begin
      pw_valid_d = accept;
      pw_idx_d   = up_idx;
      pw_state_d = ctr_next(up_cur, upd_taken);
   end

   // Pending-write stage; reset drops any write in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         pw_valid_q <= 1'b0;
         pw_idx_q   <= '0;
         pw_state_q <= RESET_STATE;
      end else begin
         pw_valid_q <= pw_valid_d;
         pw_idx_q   <= pw_idx_d;
         pw_state_q <= pw_state_d;
      end
   end

   // Single write port shared by the init sweep and the pending write.
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = init_idx_q;
      wr_data = RESET_STATE;
      if (rst) begin
         wr_en = 1'b0;
      end else if (state_q == ST_INIT) begin
         wr_en = 1'b1;
      end else if (pw_valid_q) begin
         wr_en   = 1'b1;
         wr_idx  = pw_idx_q;
         wr_data = pw_state_q;
      end else begin
         wr_en = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         table_q[wr_idx] <= wr_data;
      end
   end

`ifdef BHT_PERF_CNT_EN
   logic [31:0] perf_br_q;
   logic [31:0] perf_mp_q;

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_br_q <= 32'h0000_0000;
         perf_mp_q <= 32'h0000_0000;
      end else begin
         if (accept && (perf_br_q != 32'hFFFF_FFFF)) begin
            perf_br_q <= perf_br_q + 32'h0000_0001;
         end
         if (mispredict && (perf_mp_q != 32'hFFFF_FFFF)) begin
            perf_mp_q <= perf_mp_q + 32'h0000_0001;
         end
      end
   end

   assign perf_branches    = perf_br_q;
   assign perf_mispredicts = perf_mp_q;
`else
   assign perf_branches    = 32'h0000_0000;
   assign perf_mispredicts = 32'h0000_0000;
`endif

endmodule

// File: doc/branch_history_table.md
# branch_history_table

Direction predictor that supplies the 2-bit prediction state consumed by the BTB's `taken` input. It holds a table of 2-bit saturating counters indexed by fetch PC and is read combinationally in IF. Counters are trained from resolved conditional branches in EX through a one-stage write pipeline with forwarding. After reset it runs a sweep FSM that initialises every counter, so the table maps onto a single-write-port array.

## Interface
- `NUM_ENTRIES`, 64: number of counters; power of two, ≥4; `IDX_W = log2(NUM_ENTRIES)`.
- `RESET_STATE`, 2'b01: value written to every counter during init.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `if_pc` input 32: fetch PC to look up.
- `pred_state` output 2: counter state for `if_pc`; drives BTB `taken`.
- `pred_taken` output 1: `pred_state[1]`.
- `ready` output 1: high when the table is initialised (RUN state).
- `upd_valid` input 1: a conditional branch resolved this cycle.
- `upd_pc` input 32: PC of the resolved branch.
- `upd_taken` input 1: actual outcome.
- `upd_pred` input 2: `pred_state` carried down the pipe with that branch.
- `mispredict` output 1: combinational, `upd_valid & ready & (upd_pred[1] != upd_taken)`.
- `perf_branches` output 32: resolved-branch count.
- `perf_mispredicts` output 32: mispredict count.

## Operation
- Index is `pc[IDX_W+1:2]`; there are no tags, so aliasing is allowed.
- Counter encoding:
  - 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
  - Taken increments and saturates at 11; not-taken decrements and saturates at 00.
- FSM states:
  - INIT: the `init_idx` counter runs 0..NUM_ENTRIES-1, writing `RESET_STATE` to one entry per cycle. After writing the last entry the FSM goes to RUN.
  - RUN: normal lookup and update.
- Lookup in INIT returns `RESET_STATE`.
- Updates in INIT are dropped: no write, no mispredict, no perf count.
- Update pipeline:
  - Cycle N: accepted update (`upd_valid & ready`) reads `table[idx]` with forwarding and computes the next state. Index and state are registered into the pending-write register `pw_{valid,idx,state}`.
  - Cycle N+1: `pw_state` is written to the table at the edge ending N+1.
- Forwarding: if `pw_valid` and `pw_idx` equals an index being read, `pw_state` replaces the array value. This applies to both the lookup path and the update read path. Back-to-back updates to the same index therefore accumulate correctly.
- Simultaneous lookup and update in the same cycle: the lookup sees the pre-update value. The new value is visible from cycle N+1 via forwarding.
- Only one update is accepted per cycle.

## Timing
- Lookup latency is 0 cycles (combinational from `if_pc`).
- Update visible to lookup 1 cycle after `upd_valid`; written to the array 2 edges after.
- Reset values:
  - FSM = INIT, `init_idx` = 0, `pw_valid` = 0.
  - `ready` = 0, `pred_state` = `RESET_STATE`, `mispredict` = 0.
  - Perf counters = 0.
- `ready` rises NUM_ENTRIES cycles after the cycle in which `rst` was sampled high and then deasserted (64 by default).
- `rst` in RUN:
  - Pending write is discarded.
  - FSM returns to INIT at index 0.
  - A full re-sweep occurs.
- `rst` held high: the FSM stays in INIT with `init_idx` = 0.
- `init_idx` does not wrap. INIT→RUN happens on the edge that writes entry NUM_ENTRIES-1.

## Configuration
- `BHT_PERF_CNT_EN` defined:
  - `perf_branches` increments on each accepted update.
  - `perf_mispredicts` increments when `mispredict` is high.
  - Both are registered, saturate at 32'hFFFF_FFFF and clear on `rst`.
- Undefined: both perf ports are tied to 0 and no counter flops exist. Prediction behaviour is identical either way.

## Test plan
- Reset then idle: `ready`=0 for exactly 64 cycles, then 1; lookup of any PC returns 01 and `pred_taken`=0.
- Train PC 0x0000_0104 taken three times on consecutive cycles: lookup returns 10 one cycle after the first update, then 11, then stays 11; a fourth taken stays 11.
- Aliasing: PC 0x104 and PC 0x204 (same index) share a counter; taken on 0x104 → lookup of 0x204 returns 10.
- Mispredict: `upd_pred`=11, `upd_taken`=0 → `mispredict`=1 in the same cycle, counter becomes 10; with `BHT_PERF_CNT_EN`, `perf_branches`=1 and `perf_mispredicts`=1 the next cycle.
- Updates during INIT (cycle 10 after reset) are ignored: entry stays 01 after `ready`, `mispredict` stays 0, perf counters stay 0.
- `rst` asserted in the cycle after an update to index 5 (pending write held): after the re-sweep, entry 5 reads 01 and `ready` is low for 64 cycles.
